control_unit: RTL and testbench
===============================

# control_unit

Multicycle control FSM for the 32-bit MIPS-subset datapath. It sits directly upstream of the datapath: it consumes the instruction-register fields and ALU flags, and drives every datapath write-enable, mux select and function code. It sequences fetch, decode, execute, memory and write-back, and it handles invalid-instruction and arithmetic-overflow exceptions.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces state ST_FETCH0 and all outputs to 0 immediately.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0].
- Overflow, Zero  in  1 each  combinational ALU flags for the current cycle.
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite  out  1  enables.
- IorD  out  1  memory address: 0=PC, 1=ALUout.
- RegDest  out  1  write register: 0=RT, 1=RD.
- MemToReg  out  2  write data: 0=ALUout, 1=MDR, 2=Shiftout.
- AluSrcA  out  1  0=PC, 1=A.
- AluSrcB  out  2  0=B, 1=constant 4, 2=SignExt, 3=SignExt<<2.
- ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and.
- ShiftControl  out  3  000 hold, 001 load B, 010 sll, 011 srl, 100 sra (shift amount from IR[10:6]).
- PCSource  out  2  0=ALUResult, 1=ALUout, 2=jump address, 3=exception vector.
- ExcCode  out  1  0=invalid instruction, 1=overflow; selects the vector.
- State  out  5  current state encoding, for verification.

## Operation
- Outputs are decoded from the state. The only Mealy term is PCwrite in ST_BR. Any signal not listed for a state is 0.
- ST_FETCH0, ST_FETCH1: IorD=0. Memory read latency.
- ST_FETCH2: IRWrite=1; AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1 (PC <- PC+4).
- ST_DECODE: AluSrcA=0, AluSrcB=3, ALUControl=001 (ALUout <- branch target). Dispatch on OPCODE/FUNCT:
  - R-type (OPCODE 0x00), FUNCT 0x20/0x22/0x24 -> ST_RALU.
  - FUNCT 0x00/0x02/0x03 -> ST_SHLD.
  - FUNCT 0x08 -> ST_JR.
  - OPCODE 0x08 -> ST_ADDI; 0x23/0x2B -> ST_MADR; 0x04/0x05 -> ST_BR; 0x02 -> ST_J.
  - Anything else -> ST_EXC0 with ExcCode latched to 0.
- ST_RALU: AluSrcA=1, AluSrcB=0, ALUControl=001/010/011 per FUNCT.
  - Overflow=1 on add or sub -> ST_EXC0 with ExcCode latched to 1.
  - Otherwise -> ST_RWB.
- ST_RWB: RegDest=1, MemToReg=0, RegWrite=1 -> ST_FETCH0.
- ST_SHLD (ShiftControl=001) -> ST_SHOP (010/011/100 per FUNCT) -> ST_SHWB (RegDest=1, MemToReg=2, RegWrite=1) -> ST_FETCH0.
- ST_JR: AluSrcA=1, ALUControl=000, PCSource=0, PCwrite=1 -> ST_FETCH0.
- ST_ADDI: AluSrcA=1, AluSrcB=2, ALUControl=001.
  - Overflow -> ST_EXC0 with ExcCode=1.
  - Otherwise -> ST_IWB (RegDest=0, MemToReg=0, RegWrite=1) -> ST_FETCH0.
- ST_MADR: AluSrcA=1, AluSrcB=2, ALUControl=001.
  - lw: -> ST_LW0, ST_LW1 (IorD=1) -> ST_LW2 (IorD=1, MemRead=1) -> ST_LWWB (RegDest=0, MemToReg=1, RegWrite=1).
  - sw: -> ST_SW (IorD=1, MemWrite=1).
  - Both then -> ST_FETCH0.
- ST_BR: AluSrcA=1, AluSrcB=0, ALUControl=010, PCSource=1.
  - PCwrite = Zero for beq, ~Zero for bne.
  - -> ST_FETCH0.
- ST_J: PCSource=2, PCwrite=1 -> ST_FETCH0.
- ST_EXC0: AluSrcA=0, AluSrcB=1, ALUControl=010 (ALUout <- PC-4).
- ST_EXC1: EPCWrite=1, PCSource=3, PCwrite=1 -> ST_FETCH0.
- ExcCode is a register. It is written only on entry to ST_EXC0 and resets to 0.
- Exception paths never assert RegWrite or MemWrite, so the destination is not written.

## Timing
- Cycle counts, DECODE inclusive:
  - R-type ALU: 6. Shift: 7. jr: 5. addi: 6.
  - lw: 9. sw: 6. beq/bne: 5. j: 5.
  - Exception: 6 (DECODE -> EXC0 -> EXC1).
- The first rising edge after reset deasserts starts ST_FETCH0. Its outputs are already visible while reset is low.
- Reset asserted mid-instruction (e.g. in ST_SW) drops MemWrite/RegWrite/PCwrite in the same cycle, asynchronously. The next edge after release starts ST_FETCH0.
- The flag decision uses the combinational Overflow/Zero of the current cycle. Flags are not sampled in any other state.

## Test plan
- Reset low for 3 cycles, then high -> all outputs 0 during reset; State=ST_FETCH0 on the first cycle after release; IRWrite=1 exactly 2 cycles later.
- add, OPCODE=0x00, FUNCT=0x20, Overflow=0 -> RegWrite=1 with RegDest=1, MemToReg=0 in cycle 6; then ST_FETCH0.
- Same instruction with Overflow=1 in ST_RALU -> no RegWrite; EPCWrite=1, PCSource=3, ExcCode=1 in ST_EXC1.
- lw (0x23) -> MemRead=1 in cycle 8, RegWrite with MemToReg=1 in cycle 9. sw (0x2B) -> MemWrite=1, IorD=1 in cycle 6 only.
- beq with Zero=1 -> PCwrite=1, PCSource=1 in ST_BR. beq with Zero=0 -> PCwrite=0. bne gives the inverse in both cases.
- OPCODE=0x3F -> ST_EXC0 after DECODE with ExcCode=0. Reset asserted during ST_SW -> MemWrite falls to 0 before the next clock edge.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the 32-bit MIPS-subset datapath.
// It steps through fetch, decode, execute, memory and write-back. It also
// handles invalid-instruction and arithmetic-overflow exceptions.
//
// Ports
//   clk, reset (async, active-low)       clock and reset
//   OPCODE, FUNCT                         IR[31:26] and IR[5:0]
//   Overflow, Zero                        combinational ALU flags
//   PCwrite .. EPCWrite                   datapath write/read enables
//   IorD, RegDest, MemToReg               memory address and register-file muxes
//   AluSrcA, AluSrcB                      ALU operand muxes
//   ALUControl, ShiftControl              function codes
//   PCSource, ExcCode                     PC source mux and exception-vector select
//   State                                 current state encoding
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Zero,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       RegDest,
  output logic [1:0] MemToReg,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ShiftControl,
  output logic [1:0] PCSource,
  output logic       ExcCode,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    StFetch0 = 5'd0,  StFetch1 = 5'd1,  StFetch2 = 5'd2,  StDecode = 5'd3,
    StRalu   = 5'd4,  StRwb    = 5'd5,  StShld   = 5'd6,  StShop   = 5'd7,
    StShwb   = 5'd8,  StJr     = 5'd9,  StAddi   = 5'd10, StIwb    = 5'd11,
    StMadr   = 5'd12, StLw0    = 5'd13, StLw1    = 5'd14, StLw2    = 5'd15,
    StLwwb   = 5'd16, StSw     = 5'd17, StBr     = 5'd18, StJ      = 5'd19,
    StExc0   = 5'd20, StExc1   = 5'd21
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_write;
    logic       epc_write;
    logic       iord;
    logic       reg_dest;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] shift_control;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   exc_code_q, exc_code_d;
  logic   run_q;
  logic   br_take;

  // Moore outputs for a state. FUNCT comes from the IR, so it is stable for the
  // whole instruction once the IR is loaded in StFetch2.
  function automatic ctrl_t decode(input state_e st, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch2: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'd1; c.alu_control = 3'b001; c.pc_write = 1'b1;
      end
      StDecode: begin
        c.alu_src_b = 2'd3; c.alu_control = 3'b001;
      end
      StRalu: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = (fn == FnSub) ? 3'b010 : (fn == FnAnd) ? 3'b011 : 3'b001;
      end
      StRwb, StShwb: begin
        c.reg_dest   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = (st == StShwb) ? 2'd2 : 2'd0;
      end
      StShld: c.shift_control = 3'b001;
      StShop: c.shift_control = (fn == FnSrl) ? 3'b011 : (fn == FnSra) ? 3'b100 : 3'b010;
      StJr: begin
        c.alu_src_a = 1'b1; c.pc_write = 1'b1;
      end
      StAddi, StMadr: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_control = 3'b001;
      end
      StIwb:        c.reg_write = 1'b1;
      StLw0, StLw1: c.iord = 1'b1;
      StLw2: begin
        c.iord = 1'b1; c.mem_read = 1'b1;
      end
      StLwwb: begin
        c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
      end
      StSw: begin
        c.iord = 1'b1; c.mem_write = 1'b1;
      end
      // PCwrite here is the Zero-dependent term added outside the register.
      StBr: begin
        c.alu_src_a = 1'b1; c.alu_control = 3'b010; c.pc_source = 2'd1;
      end
      StJ: begin
        c.pc_source = 2'd2; c.pc_write = 1'b1;
      end
      StExc0: begin
        c.alu_src_b = 2'd1; c.alu_control = 3'b010;
      end
      StExc1: begin
        c.epc_write = 1'b1; c.pc_source = 2'd3; c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = StFetch0;
    exc_code_d = exc_code_q;
    unique case (state_q)
      StFetch0: state_d = StFetch1;
      StFetch1: state_d = StFetch2;
      StFetch2: state_d = StDecode;
      StDecode: begin
        if (OPCODE == OpRtype) begin
          case (FUNCT)
            FnAdd, FnSub, FnAnd: state_d = StRalu;
            FnSll, FnSrl, FnSra: state_d = StShld;
            FnJr:                state_d = StJr;
            default:             state_d = StExc0;
          endcase
        end else begin
          case (OPCODE)
            OpAddi:       state_d = StAddi;
            OpLw, OpSw:   state_d = StMadr;
            OpBeq, OpBne: state_d = StBr;
            OpJ:          state_d = StJ;
            default:      state_d = StExc0;
          endcase
        end
        if (state_d == StExc0) exc_code_d = 1'b0;
      end
      // "and" cannot overflow, so only add/sub take the exception.
      StRalu: begin
        if (Overflow && (FUNCT != FnAnd)) begin
          state_d    = StExc0;
          exc_code_d = 1'b1;
        end else begin
          state_d = StRwb;
        end
      end
      StShld: state_d = StShop;
      StShop: state_d = StShwb;
      StAddi: begin
        if (Overflow) begin
          state_d    = StExc0;
          exc_code_d = 1'b1;
        end else begin
          state_d = StIwb;
        end
      end
      StMadr:  state_d = (OPCODE == OpLw) ? StLw0 : StSw;
      StLw0:   state_d = StLw1;
      StLw1:   state_d = StLw2;
      StLw2:   state_d = StLwwb;
      StExc0:  state_d = StExc1;
      default: state_d = StFetch0;
    endcase
    // The first edge after reset release starts the StFetch0 cycle rather than leaving it.
    if (!run_q) state_d = StFetch0;
  end

  assign ctrl_d = decode(state_d, FUNCT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch0;
      ctrl_q     <= '0;
      exc_code_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      exc_code_q <= exc_code_d;
      run_q      <= 1'b1;
    end
  end

  assign br_take = (state_q == StBr) && ((OPCODE == OpBne) ? !Zero : Zero);

  assign PCwrite      = ctrl_q.pc_write | br_take;
  assign MemWrite     = ctrl_q.mem_write;
  assign MemRead      = ctrl_q.mem_read;
  assign IRWrite      = ctrl_q.ir_write;
  assign RegWrite     = ctrl_q.reg_write;
  assign EPCWrite     = ctrl_q.epc_write;
  assign IorD         = ctrl_q.iord;
  assign RegDest      = ctrl_q.reg_dest;
  assign MemToReg     = ctrl_q.mem_to_reg;
  assign AluSrcA      = ctrl_q.alu_src_a;
  assign AluSrcB      = ctrl_q.alu_src_b;
  assign ALUControl   = ctrl_q.alu_control;
  assign ShiftControl = ctrl_q.shift_control;
  assign PCSource     = ctrl_q.pc_source;
  assign ExcCode      = exc_code_q;
  assign State        = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test of control_unit. Each scenario queues the
// expected state and output vector per cycle along with the inputs for that cycle.
// It then steps the clock and compares the DUT against the queue mid-cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OPCODE, FUNCT;
  logic       Overflow, Zero;
  logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD, RegDest;
  logic [1:0] MemToReg, AluSrcB, PCSource;
  logic       AluSrcA, ExcCode;
  logic [2:0] ALUControl, ShiftControl;
  logic [4:0] State;

  control_unit dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Overflow(Overflow),
    .Zero(Zero), .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .EPCWrite(EPCWrite), .IorD(IorD),
    .RegDest(RegDest), .MemToReg(MemToReg), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .ALUControl(ALUControl), .ShiftControl(ShiftControl), .PCSource(PCSource),
    .ExcCode(ExcCode), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] StFetch0 = 5'd0,  StFetch1 = 5'd1,  StFetch2 = 5'd2;
  localparam logic [4:0] StDecode = 5'd3,  StRalu   = 5'd4,  StRwb    = 5'd5;
  localparam logic [4:0] StShld   = 5'd6,  StShop   = 5'd7,  StShwb   = 5'd8;
  localparam logic [4:0] StJr     = 5'd9,  StAddi   = 5'd10, StIwb    = 5'd11;
  localparam logic [4:0] StMadr   = 5'd12, StLw0    = 5'd13, StLw1    = 5'd14;
  localparam logic [4:0] StLw2    = 5'd15, StLwwb   = 5'd16, StSw     = 5'd17;
  localparam logic [4:0] StBr     = 5'd18, StJ      = 5'd19, StExc0   = 5'd20;
  localparam logic [4:0] StExc1   = 5'd21;

  // Enable byte order: PCwrite MemWrite MemRead IRWrite RegWrite EPCWrite IorD RegDest
  localparam logic [7:0] EnPc = 8'h80, EnMw = 8'h40, EnMr = 8'h20, EnIr = 8'h10;
  localparam logic [7:0] EnRw = 8'h08, EnEpc = 8'h04, EnIord = 8'h02, EnRd = 8'h01;
  localparam logic [7:0] En0 = 8'h00;

  int compared = 0;
  int mismatched = 0;
  logic        exc;     // expected ExcCode register value
  logic [13:0] cur_in;  // {OPCODE, FUNCT, Overflow, Zero}
  logic [4:0]  es[$];
  logic [21:0] eo[$];
  logic [13:0] ei[$];

  function automatic logic [21:0] o(input logic [7:0] en, input logic [1:0] m2r,
                                    input logic asa, input logic [1:0] asb,
                                    input logic [2:0] alu, input logic [2:0] sh,
                                    input logic [1:0] pcs, input logic e);
    return {en, m2r, asa, asb, alu, sh, pcs, e};
  endfunction

  function automatic logic [21:0] outs();
    return {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD, RegDest,
            MemToReg, AluSrcA, AluSrcB, ALUControl, ShiftControl, PCSource, ExcCode};
  endfunction

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                        input logic z);
    cur_in = {op, fn, ov, z};
  endtask

  task automatic want(input logic [4:0] st, input logic [21:0] v);
    es.push_back(st);
    eo.push_back(v);
    ei.push_back(cur_in);
  endtask

  task automatic fetch();
    want(StFetch0, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StFetch1, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StFetch2, o(EnPc | EnIr, 2'd0, 1'b0, 2'd1, 3'd1, 3'd0, 2'd0, exc));
    want(StDecode, o(En0, 2'd0, 1'b0, 2'd3, 3'd1, 3'd0, 2'd0, exc));
  endtask

  task automatic want_exc(input logic code);
    exc = code;
    want(StExc0, o(En0, 2'd0, 1'b0, 2'd1, 3'd2, 3'd0, 2'd0, exc));
    want(StExc1, o(EnPc | EnEpc, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd3, exc));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      compared++;
      if (State !== StFetch0 || outs() !== 22'h0) begin
        mismatched++;
        $display("FAIL reset_low cycle %0d: got state=%0d outs=%h, want state=0 outs=0",
                 i, State, outs());
      end
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (State !== StFetch0 || outs() !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_release: got state=%0d outs=%h, want state=0 outs=0", State, outs());
    end
    exc = 1'b0;
    set_in(6'h02, 6'h00, 1'b0, 1'b0);
    fetch();
    want(StJ, o(EnPc, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd2, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL reset_seq step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_rtype();
    set_in(6'h00, 6'h20, 1'b0, 1'b0);  // add, no overflow
    fetch();
    want(StRalu, o(En0, 2'd0, 1'b1, 2'd0, 3'd1, 3'd0, 2'd0, exc));
    want(StRwb, o(EnRw | EnRd, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    set_in(6'h00, 6'h20, 1'b1, 1'b0);  // add, overflow
    fetch();
    want(StRalu, o(En0, 2'd0, 1'b1, 2'd0, 3'd1, 3'd0, 2'd0, exc));
    want_exc(1'b1);
    set_in(6'h00, 6'h24, 1'b1, 1'b0);  // and ignores overflow
    fetch();
    want(StRalu, o(En0, 2'd0, 1'b1, 2'd0, 3'd3, 3'd0, 2'd0, exc));
    want(StRwb, o(EnRw | EnRd, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    set_in(6'h00, 6'h22, 1'b0, 1'b1);  // sub, no overflow
    fetch();
    want(StRalu, o(En0, 2'd0, 1'b1, 2'd0, 3'd2, 3'd0, 2'd0, exc));
    want(StRwb, o(EnRw | EnRd, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL rtype step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_invalid();
    set_in(6'h3F, 6'h20, 1'b0, 1'b0);
    fetch();
    want_exc(1'b0);
    set_in(6'h00, 6'h3F, 1'b0, 1'b0);  // R-type with unknown FUNCT
    fetch();
    want_exc(1'b0);
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL invalid step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_mem();
    set_in(6'h23, 6'h00, 1'b1, 1'b0);  // lw; Overflow is not sampled in MADR
    fetch();
    want(StMadr, o(En0, 2'd0, 1'b1, 2'd2, 3'd1, 3'd0, 2'd0, exc));
    want(StLw0, o(EnIord, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StLw1, o(EnIord, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StLw2, o(EnMr | EnIord, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StLwwb, o(EnRw, 2'd1, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    set_in(6'h2B, 6'h00, 1'b1, 1'b0);  // sw
    fetch();
    want(StMadr, o(En0, 2'd0, 1'b1, 2'd2, 3'd1, 3'd0, 2'd0, exc));
    want(StSw, o(EnMw | EnIord, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL mem step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_branch();
    logic [5:0] op;
    logic       z, take;
    for (int j = 0; j < 4; j++) begin
      op   = (j < 2) ? 6'h04 : 6'h05;
      z    = (j == 0 || j == 2);
      take = (op == 6'h04) ? z : !z;
      set_in(op, 6'h00, 1'b0, z);
      fetch();
      want(StBr, o(take ? EnPc : En0, 2'd0, 1'b1, 2'd0, 3'd2, 3'd0, 2'd1, exc));
    end
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL branch step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_jump();
    set_in(6'h02, 6'h08, 1'b1, 1'b1);  // j
    fetch();
    want(StJ, o(EnPc, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd2, exc));
    set_in(6'h00, 6'h08, 1'b1, 1'b0);  // jr
    fetch();
    want(StJr, o(EnPc, 2'd0, 1'b1, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL jump step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_addi();
    set_in(6'h08, 6'h00, 1'b0, 1'b0);
    fetch();
    want(StAddi, o(En0, 2'd0, 1'b1, 2'd2, 3'd1, 3'd0, 2'd0, exc));
    want(StIwb, o(EnRw, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    set_in(6'h08, 6'h00, 1'b1, 1'b0);
    fetch();
    want(StAddi, o(En0, 2'd0, 1'b1, 2'd2, 3'd1, 3'd0, 2'd0, exc));
    want_exc(1'b1);
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL addi step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_shift();
    logic [5:0] fn   [3];
    logic [2:0] code [3];
    fn[0] = 6'h00; code[0] = 3'b010;  // sll
    fn[1] = 6'h02; code[1] = 3'b011;  // srl
    fn[2] = 6'h03; code[2] = 3'b100;  // sra
    for (int j = 0; j < 3; j++) begin
      set_in(6'h00, fn[j], 1'b1, 1'b0);
      fetch();
      want(StShld, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd0, exc));
      want(StShop, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, code[j], 2'd0, exc));
      want(StShwb, o(EnRw | EnRd, 2'd2, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    end
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL shift step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  task automatic test_reset_mid_sw();
    set_in(6'h2B, 6'h00, 1'b0, 1'b0);
    fetch();
    want(StMadr, o(En0, 2'd0, 1'b1, 2'd2, 3'd1, 3'd0, 2'd0, exc));
    want(StSw, o(EnMw | EnIord, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL midreset_sw step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
    // Still inside the SW cycle: reset must clear everything before the next edge.
    #1 reset = 1'b0;
    #1;
    exc = 1'b0;
    compared++;
    if (MemWrite !== 1'b0 || State !== StFetch0 || outs() !== 22'h0) begin
      mismatched++;
      $display("FAIL midreset_async: got MemWrite=%b state=%0d outs=%h, want 0/0/0",
               MemWrite, State, outs());
    end
    @(posedge clk); #3 reset = 1'b1;
    want(StFetch0, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    want(StFetch1, o(En0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, exc));
    for (int i = 0; i < es.size(); i++) begin
      @(posedge clk); #1;
      {OPCODE, FUNCT, Overflow, Zero} = ei[i];
      #1;
      compared++;
      if (State !== es[i] || outs() !== eo[i]) begin
        mismatched++;
        $display("FAIL midreset_restart step %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 i, State, outs(), es[i], eo[i]);
      end
    end
    es.delete(); eo.delete(); ei.delete();
  endtask

  initial begin
    reset    = 1'b1;
    OPCODE   = 6'h00;
    FUNCT    = 6'h00;
    Overflow = 1'b0;
    Zero     = 1'b0;
    exc      = 1'b0;
    cur_in   = '0;
    #1 reset = 1'b0;
    test_reset();
    test_rtype();
    test_invalid();
    test_mem();
    test_branch();
    test_jump();
    test_addi();
    test_shift();
    test_reset_mid_sw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
